// File: rtl/const_ext_pkg.sv
// Shared types for the immediate-constant generator.
// Mode encoding matches the 2-bit decode field.
package const_ext_pkg;

    typedef enum logic [1:0] {
        MODE_ZEXT = 2'b00,
        MODE_SEXT = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_PFX  = 2'b11
    } mode_e;

    typedef enum logic {
        PFX_EMPTY = 1'b0,
        PFX_ARMED = 1'b1
    } pfx_state_e;

endpackage

// File: rtl/const_ext_core.sv
// Combinational operand builder: extension, prefix splice, shift.
// Upper bits come from the prefix when armed, else from the mode.
module const_ext_core
    import const_ext_pkg::*;
#(
    parameter int IMM_W  = 6,
    parameter int DATA_W = 8,
    parameter int SHIFT  = 1
) (
    input  mode_e                     mode,
    input  logic [IMM_W-1:0]          imm,
    input  logic                      pfx_armed,
    input  logic [DATA_W-IMM_W-1:0]   pfx_reg,
    output logic [DATA_W-1:0]         result
);

    localparam int PW = DATA_W - IMM_W;

    logic [PW-1:0]     upper;
    logic [DATA_W-1:0] cat;

    always_comb begin
        upper = '0;
        if (pfx_armed)
            upper = pfx_reg;
        else if (mode == MODE_SEXT)
            upper = {PW{imm[IMM_W-1]}};
        cat    = {upper, imm};
        result = cat;
        if (mode == MODE_SHL)
            result = cat << SHIFT;
    end

endmodule

// File: rtl/const_ext_unit.sv
// Pipelined immediate-constant generator with prefix support.
// Holds the prefix FSM, one output register and both handshakes.
module const_ext_unit
    import const_ext_pkg::*;
#(
    parameter int IMM_W  = 6,
    parameter int DATA_W = 8,
    parameter int SHIFT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext_data,
    output logic              used_pfx,
    output logic              pfx_armed
);

    localparam int PW = DATA_W - IMM_W;

    mode_e             op_mode;
    pfx_state_e        state;
    pfx_state_e        state_nxt;
    logic [PW-1:0]     pfx_reg;
    logic [DATA_W-1:0] core_data;
    logic              accept;
    logic              is_pfx;

    assign op_mode   = mode_e'(mode);
    assign is_pfx    = (op_mode == MODE_PFX);
    assign in_ready  = !out_valid || out_ready;
    // Flush squashes any input presented alongside it.
    assign accept    = in_valid && in_ready && !flush;
    assign pfx_armed = (state == PFX_ARMED);

    const_ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .SHIFT  (SHIFT)
    ) u_core (
        .mode      (op_mode),
        .imm       (imm),
        .pfx_armed (pfx_armed),
        .pfx_reg   (pfx_reg),
        .result    (core_data)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= PFX_EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = PFX_EMPTY;
        else if (accept)
            state_nxt = is_pfx ? PFX_ARMED : PFX_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pfx_reg <= '0;
        else if (accept && is_pfx)
            pfx_reg <= imm[PW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ext_data  <= '0;
            used_pfx  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            used_pfx  <= 1'b0;
        end else if (accept && !is_pfx) begin
            out_valid <= 1'b1;
            ext_data  <= core_data;
            used_pfx  <= pfx_armed;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_const_ext_unit.sv
// Directed and randomized checks of const_ext_unit
// against a transaction-level arithmetic reference.
module tb_const_ext_unit;

    localparam int IW = 6;
    localparam int DW = 8;
    localparam int SH = 1;
    localparam int PW = DW - IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    mode;
    logic [IW-1:0] imm;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] ext_data;
    logic          used_pfx;
    logic          pfx_armed;

    int nvec = 0;
    int nerr = 0;

    const_ext_unit #(
        .IMM_W  (IW),
        .DATA_W (DW),
        .SHIFT  (SH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext_data  (ext_data),
        .used_pfx  (used_pfx),
        .pfx_armed (pfx_armed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int m, input int i);
        in_valid = v;
        mode     = 2'(m);
        imm      = IW'(i);
    endtask

    // Operand value computed with plain arithmetic.
    function automatic int ref_val(int m, int i, bit armed, int p);
        int v;
        if (armed)
            v = p * (1 << IW) + i;
        else if (m == 1 && i >= (1 << (IW - 1)))
            v = i + ((1 << DW) - (1 << IW));
        else
            v = i;
        if (m == 2)
            v = (v * (1 << SH)) % (1 << DW);
        return v;
    endfunction

    bit m_valid;
    int m_data;
    bit m_used;
    bit m_armed;
    int m_pfx;
    bit acc;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_data", 32'(ext_data), 0);
        chk("rst_used", 32'(used_pfx), 0);
        chk("rst_armed", 32'(pfx_armed), 0);
        chk("rst_rdy", 32'(in_ready), 1);

        drive(1, 0, 6'b010110); cyc();
        chk("zext_ov", 32'(out_valid), 1);
        chk("zext", 32'(ext_data), 8'b00010110);
        chk("zext_used", 32'(used_pfx), 0);

        drive(1, 1, 6'b110011); cyc();
        chk("sext_neg", 32'(ext_data), 8'b11110011);
        drive(1, 1, 6'b010011); cyc();
        chk("sext_pos", 32'(ext_data), 8'b00010011);
        chk("sext_ov", 32'(out_valid), 1);

        drive(1, 2, 6'b110011); cyc();
        chk("shl", 32'(ext_data), 8'b01100110);

        drive(1, 3, 6'b000010); cyc();
        chk("pfx_armed", 32'(pfx_armed), 1);
        chk("pfx_drain", 32'(out_valid), 0);
        drive(1, 1, 6'b110011); cyc();
        chk("pfx_sext", 32'(ext_data), 8'b10110011);
        chk("pfx_used", 32'(used_pfx), 1);
        chk("pfx_gone", 32'(pfx_armed), 0);
        drive(1, 1, 6'b110011); cyc();
        chk("post_pfx", 32'(ext_data), 8'b11110011);
        chk("post_used", 32'(used_pfx), 0);

        drive(0, 0, 0); cyc();
        out_ready = 1'b0;
        drive(1, 0, 6'h01); cyc();
        chk("bp_first", 32'(ext_data), 8'h01);
        chk("bp_rdy", 32'(in_ready), 0);
        drive(1, 0, 6'h02); cyc();
        chk("bp_hold", 32'(ext_data), 8'h01);
        chk("bp_hold_ov", 32'(out_valid), 1);
        out_ready = 1'b1;
        #1;
        chk("bp_release", 32'(in_ready), 1);
        cyc();
        chk("bp_second", 32'(ext_data), 8'h02);
        chk("bp_second_ov", 32'(out_valid), 1);
        drive(0, 0, 0); cyc();
        chk("bp_empty", 32'(out_valid), 0);

        drive(1, 3, 6'b000011); cyc();
        chk("fl_armed", 32'(pfx_armed), 1);
        flush = 1'b1;
        drive(1, 0, 6'h3f); cyc();
        flush = 1'b0;
        chk("fl_unarm", 32'(pfx_armed), 0);
        chk("fl_discard", 32'(out_valid), 0);
        drive(1, 3, 6'b000011); cyc();
        out_ready = 1'b0;
        drive(1, 0, 6'h01); cyc();
        chk("fl_pre", 32'(ext_data), 8'hC1);
        chk("fl_pre_used", 32'(used_pfx), 1);
        flush = 1'b1;
        drive(1, 0, 6'h3f); cyc();
        flush = 1'b0;
        chk("fl_ov", 32'(out_valid), 0);
        chk("fl_used", 32'(used_pfx), 0);
        chk("fl_armed0", 32'(pfx_armed), 0);
        out_ready = 1'b1;
        drive(1, 0, 6'h05); cyc();
        chk("fl_after", 32'(ext_data), 8'h05);
        chk("fl_after_used", 32'(used_pfx), 0);

        drive(1, 3, 6'b000010); cyc();
        rst = 1'b1;
        drive(1, 0, 6'h09); cyc();
        rst = 1'b0;
        chk("mr_ov", 32'(out_valid), 0);
        chk("mr_armed", 32'(pfx_armed), 0);
        out_ready = 1'b0;
        drive(1, 0, 6'h09); cyc();
        chk("mr_held", 32'(out_valid), 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("mr_ov2", 32'(out_valid), 0);
        chk("mr_data", 32'(ext_data), 0);
        out_ready = 1'b1;
        drive(1, 1, 6'b110011); cyc();
        chk("mr_nopfx", 32'(ext_data), 8'b11110011);
        chk("mr_used", 32'(used_pfx), 0);

        drive(0, 0, 0); cyc();
        m_valid = 0; m_data = 0; m_used = 0;
        m_armed = 0; m_pfx = 0;
        for (int n = 0; n < 500; n++) begin
            in_valid  = ($urandom % 4) != 0;
            mode      = 2'($urandom);
            imm       = IW'($urandom);
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 16) == 0;
            #1;
            chk("rnd_rdy", 32'(in_ready),
                32'(!m_valid || out_ready));
            acc = in_valid && (!m_valid || out_ready) && !flush;
            if (flush) begin
                m_valid = 0; m_used = 0; m_armed = 0;
            end else if (acc && mode == 2'd3) begin
                m_armed = 1;
                m_pfx   = int'(imm) % (1 << PW);
                if (m_valid && out_ready) m_valid = 0;
            end else if (acc) begin
                m_data  = ref_val(int'(mode), int'(imm),
                                  m_armed, m_pfx);
                m_used  = m_armed;
                m_armed = 0;
                m_valid = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            cyc();
            chk("rnd_ov", 32'(out_valid), 32'(m_valid));
            chk("rnd_armed", 32'(pfx_armed), 32'(m_armed));
            if (m_valid) begin
                chk("rnd_data", 32'(ext_data), 32'(m_data));
                chk("rnd_used", 32'(used_pfx), 32'(m_used));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule

// File: doc/const_ext_unit.md
# const_ext_unit

Parametrised, pipelined immediate-constant generator for the datapath decode stage. It takes an IMM_W-bit instruction immediate and produces a DATA_W-bit operand by zero-extension, sign-extension or scaled shift. It also supports a prefix mechanism: one prefix instruction supplies the upper operand bits for the next consuming instruction, so full-width constants can be built. Valid/ready handshakes on both sides and one registered output stage let it sit between decode and the register-read/ALU-operand mux.

## Interface
- IMM_W, 6, immediate field width; legal range 2..16
- DATA_W, 8, operand width; requires IMM_W < DATA_W <= 2*IMM_W
- SHIFT, 1, left-shift amount for SHL mode; 0..DATA_W-1
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous pipeline flush (branch redirect)
- in_valid  input  1  immediate/mode present
- in_ready  output  1  block can accept input this cycle
- mode  input  2  00 ZEXT, 01 SEXT, 10 SHL, 11 PFX
- imm  input  IMM_W  instruction immediate field
- out_valid  output  1  ext_data valid
- out_ready  input  1  consumer accepts ext_data
- ext_data  output  DATA_W  extended operand
- used_pfx  output  1  ext_data was built from an armed prefix
- pfx_armed  output  1  a prefix is held, waiting for a consumer

## Operation
- Input handshake when in_valid && in_ready; output handshake when out_valid && out_ready.
- Let PW = DATA_W-IMM_W. Build base without prefix as follows:
  - ZEXT: {PW zeros, imm}.
  - SEXT: {PW copies of imm[IMM_W-1], imm}.
  - SHL: (ZEXT value << SHIFT), truncated to DATA_W bits with zero fill.
- With a prefix armed, ZEXT and SEXT produce {pfx_reg[PW-1:0], imm}. SHL produces that same concatenation shifted left by SHIFT and truncated.
- PFX mode: on accept, capture imm[PW-1:0] into pfx_reg and set pfx_armed. No output beat is produced. Upper imm bits above PW are ignored.
- Prefix state machine:
  - EMPTY -> ARMED on an accepted PFX.
  - ARMED -> EMPTY on an accepted non-PFX, which consumes the prefix and sets used_pfx=1 on that output beat.
  - ARMED -> ARMED on an accepted PFX; the new prefix overwrites the old one.
  - A prefix persists indefinitely until it is consumed or flushed.
- Flush clears out_valid, pfx_armed and used_pfx. An input presented in the same cycle as flush is discarded; it is not accepted even if in_ready=1.

## Timing
- Reset values: out_valid=0, ext_data=0, used_pfx=0, pfx_armed=0, pfx_reg=0. in_ready=1 after reset.
- in_ready = !out_valid || out_ready, combinational with no dependence on in_valid. Full throughput is one beat per cycle.
- Latency: a non-PFX input accepted at cycle N gives out_valid=1 with ext_data at cycle N+1.
- PFX accepted at cycle N: pfx_armed=1 from cycle N+1. A non-PFX accepted at cycle N+1 uses that prefix. Back-to-back PFX then op is allowed.
- Backpressure: while out_valid && !out_ready, ext_data and used_pfx hold stable and in_ready=0.
- An accepted PFX while out_valid && out_ready=1: the output beat drains and out_valid falls next cycle.
- Simultaneous events:
  - out handshake plus new non-PFX accept in the same cycle: the register is reloaded and out_valid stays 1.
  - rst dominates flush, and flush dominates accept.
- Reset mid-operation: any held beat and any armed prefix are lost, with no output.

## Structure
- Package const_ext_pkg:
  - mode_e enum: MODE_ZEXT=2'b00, MODE_SEXT=2'b01, MODE_SHL=2'b10, MODE_PFX=2'b11.
  - pfx_state_e: PFX_EMPTY, PFX_ARMED.
- Sub-module const_ext_core: purely combinational. Inputs are mode, imm, pfx_armed and pfx_reg; output is the DATA_W result. The top level holds the prefix FSM, output register and handshake.

## Test plan
- Default params, ZEXT imm=6'b010110 -> ext_data=8'b00010110 one cycle later, used_pfx=0.
- SEXT imm=6'b110011 -> 8'b11110011; SEXT imm=6'b010011 -> 8'b00010011, on back-to-back cycles with out_ready=1 and no bubble.
- SHL imm=6'b110011, SHIFT=1 -> 8'b01100110.
- PFX imm=6'b000010, then SEXT imm=6'b110011 -> 8'b10110011 with used_pfx=1, pfx_armed=0 afterwards. A following SEXT 6'b110011 -> 8'b11110011.
- out_ready=0 with two ZEXT inputs 6'h01, 6'h02 -> first held at 8'h01, in_ready=0, second stalls. Release out_ready -> 8'h01 then 8'h02, none lost or duplicated.
- PFX 6'b000011, then flush while out_valid=1 -> next cycle out_valid=0, pfx_armed=0. ZEXT 6'h05 -> 8'h05 with used_pfx=0. rst asserted mid-stream gives the same cleared state.
